// File: rtl/instr_fill_pkg.sv
// Shared definitions for the instruction-cache fill responder.
//   t_fill_state : responder FSM states
//   cnt_width()  : width of a counter that must hold 0..words inclusive
//   BEAT_CNT_W / ISSUE_CNT_W : counter widths for the default 16-word block
package instr_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } t_fill_state;

  localparam int DEF_BLOCK_WORDS = 16;

  // One extra bit so the issue counter can reach BLOCK_WORDS itself,
  // which is how "everything issued" is detected.
  function automatic int cnt_width(input int words);
    return $clog2(words) + 1;
  endfunction

  localparam int BEAT_CNT_W  = cnt_width(DEF_BLOCK_WORDS);
  localparam int ISSUE_CNT_W = cnt_width(DEF_BLOCK_WORDS);

endpackage

// File: rtl/instr_fill_responder_if.sv
// Fill channel between the instruction-cache FSM (master) and the
// memory-side fill responder (slave).
//   start_read : level-held fill request (master -> slave)
//   addr       : miss byte address, sampled when the request is accepted
//   r_ready    : master accepts the presented beat
//   r_valid    : beat valid (slave -> master)
//   r_data     : beat data
//   r_last     : final beat of the block, qualified by r_valid
interface instr_fill_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  start_read;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  modport master (
    output start_read, addr, r_ready,
    input  r_valid, r_data, r_last
  );

  modport slave (
    input  start_read, addr, r_ready,
    output r_valid, r_data, r_last
  );
endinterface

// File: rtl/fill_skid_fifo.sv
// Small synchronous return buffer for fill beats.
//   clk, arst : clock, asynchronous active-high reset
//   push      : write wdata (ignored while flush is high)
//   pop       : drop the head entry (caller only pops when not empty)
//   flush     : discard all contents; wins over push and pop
//   rdata     : head entry, valid whenever empty is low
//   empty/full/occupancy : fill level
module fill_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [OCC_W-1:0] occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // Simultaneous push and pop leaves the count unchanged.
      count_reg <= count_reg + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata     = mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == OCC_W'(DEPTH));
  assign occupancy = count_reg;
endmodule

// File: rtl/instr_fill_responder.sv
// Memory-side responder for instruction-cache line fills. On a fill
// request it reads one aligned block from a 1-cycle synchronous memory and
// streams it back beat by beat over a valid/ready channel.
//   clk, arst : clock, asynchronous active-high reset
//   fill      : fill channel (slave side)
//   busy      : responder not idle
//   mem_rd_en : memory read strobe
//   mem_addr  : memory byte address (0 when no read is issued)
//   mem_rdata : memory data, valid the cycle after mem_rd_en
module instr_fill_responder
  import instr_fill_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int SKID_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  instr_fill_responder_if.slave fill,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = cnt_width(BLOCK_WORDS);
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_WORDS * BYTES - 1);

  t_fill_state           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [CNT_W-1:0]      issued_reg;
  logic [CNT_W-1:0]      beat_reg;
  logic                  inflight_reg;

  logic                  rd_en, valid, pop, push, flush;
  logic                  empty, full, last_beat, all_issued;
  logic [DATA_WIDTH-1:0] head;
  logic [OCC_W-1:0]      occupancy;

  assign last_beat  = (beat_reg == CNT_W'(BLOCK_WORDS - 1));
  assign all_issued = (issued_reg == CNT_W'(BLOCK_WORDS));
  // Returning data is only kept while the fill is live; in FLUSH it is dropped.
  assign push       = (state_reg == READ) && inflight_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    valid      = 1'b0;
    pop        = 1'b0;
    rd_en      = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fill.start_read) state_next = READ;
      end
      READ: begin
        if (!fill.start_read) begin
          // Abort: nothing is presented or issued from this cycle on.
          state_next = FLUSH;
          flush      = 1'b1;
        end else begin
          valid = !empty;
          pop   = valid && fill.r_ready;
          // Issue only if the beat will have a buffer slot when it returns,
          // counting the read already in flight and the slot freed this cycle.
          rd_en = !all_issued &&
                  ((SUM_W'(occupancy) + SUM_W'(inflight_reg)) <
                   (SUM_W'(SKID_DEPTH) + SUM_W'(pop)));
          if (pop && last_beat) state_next = DONE;
        end
      end
      DONE: begin
        if (!fill.start_read) state_next = IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        if (!inflight_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      base_reg     <= '0;
      issued_reg   <= '0;
      beat_reg     <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (state_reg == IDLE && fill.start_read) begin
        base_reg   <= fill.addr & ~OFFSET_MASK;
        issued_reg <= '0;
        beat_reg   <= '0;
      end else begin
        if (rd_en) issued_reg <= issued_reg + CNT_W'(1);
        if (pop)   beat_reg   <= beat_reg + CNT_W'(1);
      end
    end
  end

  fill_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_WIDTH),
    .OCC_W (OCC_W)
  ) u_skid (
    .clk       (clk),
    .arst      (arst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wdata     (mem_rdata),
    .rdata     (head),
    .empty     (empty),
    .full      (full),
    .occupancy (occupancy)
  );

  assign fill.r_valid = valid;
  assign fill.r_data  = valid ? head : '0;
  assign fill.r_last  = valid && last_beat;
  assign busy         = (state_reg != IDLE);
  assign mem_rd_en    = rd_en;
  assign mem_addr     = rd_en ? base_reg + ADDR_WIDTH'(issued_reg) * ADDR_WIDTH'(BYTES) : '0;

  // The issue rule guarantees a free slot for every returning beat.
  a_no_overflow: assert property (@(posedge clk) disable iff (arst) !(push && full));
endmodule

// File: tb/tb_instr_fill_responder.sv
// Self-checking bench for instr_fill_responder. A behavioural memory returns
// addr ^ salt one cycle after each read; the expected stream is the ordered
// list of words of the aligned block, checked beat by beat.
module tb_instr_fill_responder;
  import instr_fill_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 16;
  localparam int SD    = 2;
  localparam int BYTES = DW / 8;
  localparam logic [AW-1:0] BLK_MASK = ~AW'(BW * BYTES - 1);

  logic          clk = 1'b0;
  logic          arst;
  logic          busy, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] salt;

  int errors = 0;
  int checks = 0;

  logic          s_valid, s_last, s_rd_en, s_busy;
  logic [DW-1:0] s_data;
  logic [AW-1:0] s_addr;

  instr_fill_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fill();

  instr_fill_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_WORDS(BW),
    .SKID_DEPTH (SD)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .fill      (fill),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) ^ salt;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_word(mem_addr);
  end

  // Inputs are driven at posedge+1; outputs are sampled at the negedge.
  task automatic step();
    @(negedge clk);
    s_valid = fill.r_valid;
    s_data  = fill.r_data;
    s_last  = fill.r_last;
    s_rd_en = mem_rd_en;
    s_addr  = mem_addr;
    s_busy  = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    fill.start_read = 1'b0;
    fill.addr = '0;
    fill.r_ready = 1'b0;
    salt = '0;
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", s_valid); end
    checks++; if (s_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", s_data); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", s_last); end
    checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", s_rd_en); end
    checks++; if (s_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", s_addr); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", s_busy); end
    arst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle k=%0d got busy=%0b valid=%0b exp 0/0", k, s_busy, s_valid);
      end
    end
    $display("test_reset done errors=%0d", errors);
  endtask

  // Exact cycle timeline of one fill with ready held high.
  task automatic test_basic_fill();
    logic [AW-1:0] base;
    logic exp_rd, exp_v, exp_b;
    salt = '0;
    fill.addr = 32'h0000_1234;
    fill.r_ready = 1'b1;
    base = fill.addr & BLK_MASK;
    for (int t = 0; t <= 22; t++) begin
      fill.start_read = (t <= BW + 3);
      step();
      exp_rd = (t >= 1 && t <= BW);
      exp_v  = (t >= 3 && t <= BW + 2);
      exp_b  = (t >= 1 && t <= BW + 4);
      checks++;
      if (s_rd_en !== exp_rd) begin errors++; $display("FAIL basic_rd_en t=%0d got=%0b exp=%0b", t, s_rd_en, exp_rd); end
      if (exp_rd) begin
        checks++;
        if (s_addr !== base + AW'((t - 1) * BYTES)) begin
          errors++; $display("FAIL basic_addr t=%0d got=%h exp=%h", t, s_addr, base + AW'((t - 1) * BYTES));
        end
      end
      checks++;
      if (s_valid !== exp_v) begin errors++; $display("FAIL basic_valid t=%0d got=%0b exp=%0b", t, s_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (s_data !== base + AW'((t - 3) * BYTES) || s_last !== (t == BW + 2)) begin
          errors++; $display("FAIL basic_beat t=%0d got d=%h l=%0b exp d=%h l=%0b", t, s_data, s_last,
                             base + AW'((t - 3) * BYTES), (t == BW + 2));
        end
      end
      checks++;
      if (s_busy !== exp_b) begin errors++; $display("FAIL basic_busy t=%0d got=%0b exp=%0b", t, s_busy, exp_b); end
    end
    $display("test_basic_fill done errors=%0d", errors);
  endtask

  // Three stall cycles while beat 4 is presented.
  task automatic test_backpressure();
    logic [AW-1:0] base;
    int idx, issued, stalls, t;
    salt = '0;
    fill.addr = 32'h0000_1234;
    base = fill.addr & BLK_MASK;
    fill.start_read = 1'b1;
    idx = 0; issued = 0; stalls = 0; t = 0;
    while (idx < BW && t < 100) begin
      fill.r_ready = !(idx == 4 && stalls < 3);
      step();
      if (s_rd_en) begin
        checks++;
        if (s_addr !== base + AW'(issued * BYTES)) begin
          errors++; $display("FAIL bp_addr n=%0d got=%h exp=%h", issued, s_addr, base + AW'(issued * BYTES));
        end
        issued++;
      end
      if (s_valid) begin
        checks++;
        if (s_data !== base + AW'(idx * BYTES) || s_last !== (idx == BW - 1)) begin
          errors++; $display("FAIL bp_beat idx=%0d got d=%h l=%0b exp d=%h l=%0b", idx, s_data, s_last,
                             base + AW'(idx * BYTES), (idx == BW - 1));
        end
        if (fill.r_ready) idx++;
        else begin
          stalls++;
          checks++;
          if (s_data !== 32'h0000_1210 || s_rd_en !== 1'b0) begin
            errors++; $display("FAIL bp_stall s=%0d got d=%h rd=%0b exp d=00001210 rd=0", stalls, s_data, s_rd_en);
          end
        end
      end
      checks++;
      if (issued - idx > SD) begin errors++; $display("FAIL bp_outstanding got=%0d exp<=%0d", issued - idx, SD); end
      t++;
    end
    checks++;
    if (idx != BW || issued != BW || stalls != 3) begin
      errors++; $display("FAIL bp_count got beats=%0d issued=%0d stalls=%0d exp %0d/%0d/3", idx, issued, stalls, BW, BW);
    end
    fill.r_ready = 1'b1;
    step();
    fill.start_read = 1'b0;
    step();
    step();
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%0b exp=0", s_busy); end
    $display("test_backpressure done errors=%0d", errors);
  endtask

  // Alternating then random ready against the ordered-block model.
  task automatic test_ready_patterns();
    logic [AW-1:0] base, req;
    logic [DW-1:0] pd;
    logic pv, pr;
    int idx, issued, t, lasts;
    for (int it = 0; it < 6; it++) begin
      salt = $urandom;
      req  = $urandom;
      base = req & BLK_MASK;
      idx = 0; issued = 0; t = 0; lasts = 0; pv = 1'b0; pr = 1'b0; pd = '0;
      fill.addr = req;
      fill.start_read = 1'b1;
      while (idx < BW && t < 200) begin
        fill.r_ready = (it < 2) ? (t % 2 == 0) : ($urandom_range(0, 3) != 0);
        step();
        if (pv && !pr) begin
          checks++;
          if (s_valid !== 1'b1 || s_data !== pd) begin
            errors++; $display("FAIL rp_stable it=%0d t=%0d got v=%0b d=%h exp v=1 d=%h", it, t, s_valid, s_data, pd);
          end
        end
        if (s_rd_en) begin
          checks++;
          if (s_addr !== base + AW'(issued * BYTES)) begin
            errors++; $display("FAIL rp_addr it=%0d got=%h exp=%h", it, s_addr, base + AW'(issued * BYTES));
          end
          issued++;
        end
        if (s_valid) begin
          checks++;
          if (s_data !== mem_word(base + AW'(idx * BYTES)) || s_last !== (idx == BW - 1)) begin
            errors++; $display("FAIL rp_beat it=%0d idx=%0d got d=%h l=%0b exp d=%h l=%0b", it, idx, s_data, s_last,
                               mem_word(base + AW'(idx * BYTES)), (idx == BW - 1));
          end
          if (fill.r_ready) begin
            if (s_last) lasts++;
            idx++;
          end
        end
        checks++;
        if (issued - idx > SD) begin errors++; $display("FAIL rp_outstanding it=%0d got=%0d exp<=%0d", it, issued - idx, SD); end
        pv = s_valid; pr = fill.r_ready; pd = s_data;
        t++;
      end
      checks++;
      if (idx != BW || issued != BW || lasts != 1) begin
        errors++; $display("FAIL rp_count it=%0d got beats=%0d issued=%0d lasts=%0d exp %0d/%0d/1", it, idx, issued, lasts, BW, BW);
      end
      step();
      checks++;
      if (s_busy !== 1'b1 || s_valid !== 1'b0 || s_rd_en !== 1'b0) begin
        errors++; $display("FAIL rp_done it=%0d got busy=%0b v=%0b rd=%0b exp 1/0/0", it, s_busy, s_valid, s_rd_en);
      end
      fill.start_read = 1'b0;
      step();
      step();
      checks++;
      if (s_busy !== 1'b0) begin errors++; $display("FAIL rp_idle it=%0d got busy=%0b exp=0", it, s_busy); end
    end
    $display("test_ready_patterns done errors=%0d", errors);
  endtask

  // Drop the request after beat 6, then run a clean fill at 0x40.
  task automatic test_abort();
    logic [AW-1:0] base;
    int idx, issued, t;
    salt = $urandom;
    fill.addr = $urandom;
    base = fill.addr & BLK_MASK;
    fill.r_ready = 1'b1;
    fill.start_read = 1'b1;
    idx = 0; t = 0;
    while (idx < 7 && t < 50) begin
      step();
      if (s_valid) begin
        checks++;
        if (s_data !== mem_word(base + AW'(idx * BYTES))) begin
          errors++; $display("FAIL ab_beat idx=%0d got=%h exp=%h", idx, s_data, mem_word(base + AW'(idx * BYTES)));
        end
        idx++;
      end
      t++;
    end
    checks++;
    if (idx != 7) begin errors++; $display("FAIL ab_timeout got beats=%0d exp=7", idx); end
    fill.start_read = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b0 || s_rd_en !== 1'b0) begin
        errors++; $display("FAIL ab_quiet k=%0d got v=%0b rd=%0b exp 0/0", k, s_valid, s_rd_en);
      end
      if (k == 2) begin
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL ab_idle got busy=%0b exp=0", s_busy); end
      end
    end
    salt = $urandom;
    fill.addr = 32'h0000_0040;
    base = 32'h0000_0040;
    fill.start_read = 1'b1;
    idx = 0; issued = 0; t = 0;
    while (idx < BW && t < 50) begin
      step();
      if (s_rd_en) begin
        checks++;
        if (s_addr !== base + AW'(issued * BYTES)) begin
          errors++; $display("FAIL ab2_addr n=%0d got=%h exp=%h", issued, s_addr, base + AW'(issued * BYTES));
        end
        issued++;
      end
      if (s_valid) begin
        if (idx == 0) begin
          checks++;
          if (t != 3) begin errors++; $display("FAIL ab2_latency got t=%0d exp t=3", t); end
        end
        checks++;
        if (s_data !== mem_word(base + AW'(idx * BYTES)) || s_last !== (idx == BW - 1)) begin
          errors++; $display("FAIL ab2_beat idx=%0d got d=%h l=%0b exp d=%h l=%0b", idx, s_data, s_last,
                             mem_word(base + AW'(idx * BYTES)), (idx == BW - 1));
        end
        idx++;
      end
      t++;
    end
    checks++;
    if (idx != BW) begin errors++; $display("FAIL ab2_count got=%0d exp=%0d", idx, BW); end
    step();
    fill.start_read = 1'b0;
    step();
    step();
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL ab2_idle got busy=%0b exp=0", s_busy); end
    $display("test_abort done errors=%0d", errors);
  endtask

  // Request held 5 cycles past the last beat must not start another fill.
  task automatic test_held_request();
    logic [AW-1:0] base;
    int idx, t;
    salt = $urandom;
    fill.addr = $urandom;
    base = fill.addr & BLK_MASK;
    fill.r_ready = 1'b1;
    fill.start_read = 1'b1;
    idx = 0; t = 0;
    while (idx < BW && t < 50) begin
      step();
      if (s_valid) begin
        checks++;
        if (s_data !== mem_word(base + AW'(idx * BYTES))) begin
          errors++; $display("FAIL held_beat idx=%0d got=%h exp=%h", idx, s_data, mem_word(base + AW'(idx * BYTES)));
        end
        idx++;
      end
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s_busy !== 1'b1 || s_rd_en !== 1'b0 || s_valid !== 1'b0) begin
        errors++; $display("FAIL held_done k=%0d got busy=%0b rd=%0b v=%0b exp 1/0/0", k, s_busy, s_rd_en, s_valid);
      end
    end
    fill.start_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (s_rd_en !== 1'b0 || s_valid !== 1'b0 || (k >= 1 && s_busy !== 1'b0)) begin
        errors++; $display("FAIL held_release k=%0d got busy=%0b rd=%0b v=%0b exp busy=%0b rd=0 v=0",
                           k, s_busy, s_rd_en, s_valid, (k == 0));
      end
    end
    $display("test_held_request done errors=%0d", errors);
  endtask

  // Asynchronous reset while beat 5 is on the channel.
  task automatic test_reset_mid_burst();
    int idx, t;
    salt = $urandom;
    fill.addr = $urandom;
    fill.r_ready = 1'b1;
    fill.start_read = 1'b1;
    idx = 0; t = 0;
    while (idx < 5 && t < 50) begin
      step();
      if (s_valid && fill.r_ready) idx++;
      t++;
    end
    checks++;
    if (fill.r_valid !== 1'b1 || idx != 5) begin
      errors++; $display("FAIL rst_pre got v=%0b beats=%0d exp v=1 beats=5", fill.r_valid, idx);
    end
    #2;
    arst = 1'b1;
    fill.start_read = 1'b0;
    #1;
    checks++;
    if (fill.r_valid !== 1'b0 || fill.r_data !== '0 || fill.r_last !== 1'b0 ||
        busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL rst_async got v=%0b d=%h l=%0b busy=%0b rd=%0b a=%h exp all 0",
                         fill.r_valid, fill.r_data, fill.r_last, busy, mem_rd_en, mem_addr);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b0 || s_rd_en !== 1'b0 || s_busy !== 1'b0) begin
        errors++; $display("FAIL rst_after k=%0d got v=%0b rd=%0b busy=%0b exp 0/0/0", k, s_valid, s_rd_en, s_busy);
      end
    end
    $display("test_reset_mid_burst done errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_ready_patterns();
    test_abort();
    test_held_request();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fill_responder.md
Name: instr_fill_responder

Overview:
- Memory-side responder for instruction-cache line fills.
- Serves the fill initiator's level-held start_read request. Reads one cache block from a synchronous-read backing memory and streams it back as DATA_WIDTH beats over a valid/ready channel.
- Flags the final beat with r_last.
- Sits between the instruction cache FSM and the instruction memory / bus bridge.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, beat/word width; multiple of 8.
- BLOCK_WORDS, 16, beats per cache block; power of two, >=2.
- SKID_DEPTH, 2, return-buffer entries; >=2.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- i_start_read  in  1  fill request; initiator holds it high until the cycle after the last beat is accepted.
- i_addr  in  ADDR_WIDTH  miss address; sampled only on acceptance.
- i_r_ready  in  1  initiator accepts a beat.
- o_r_valid  out  1  beat valid.
- o_r_data  out  DATA_WIDTH  beat data.
- o_r_last  out  1  final beat of block; qualified by o_r_valid.
- o_busy  out  1  not in IDLE.
- o_mem_rd_en  out  1  memory read strobe.
- o_mem_addr  out  ADDR_WIDTH  memory byte address.
- i_mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after o_mem_rd_en.

Behaviour:
- Reset (arst async, active-high): state IDLE; all counters, buffer pointers and in-flight flag cleared. Every output is 0. Reset mid-burst discards all data; no beat appears afterwards.
- States: IDLE, READ, DONE, FLUSH.
- IDLE -> READ when i_start_read=1.
  - Latch base = i_addr with the low log2(BLOCK_WORDS*DATA_WIDTH/8) bits zeroed.
  - Clear issue count and beat count.
- READ, issue side:
  - o_mem_rd_en=1 when issued < BLOCK_WORDS and (occupancy + inflight - pop) < SKID_DEPTH, where pop = o_r_valid & i_r_ready.
  - o_mem_addr = base + issued*(DATA_WIDTH/8), incrementing only; no wrap.
- READ, return side:
  - i_mem_rdata is pushed into the buffer in the cycle after rd_en.
  - o_r_valid = buffer not empty; o_r_data = buffer head.
  - o_r_last = o_r_valid & (beat count == BLOCK_WORDS-1).
  - A beat is transferred only when o_r_valid & i_r_ready. o_r_valid and o_r_data stay stable until the beat is accepted.
- Latency and throughput:
  - Start sampled in cycle T: first rd_en in T+1, first o_r_valid in T+3.
  - With i_r_ready held high, one beat per cycle. Full block is transferred in T+3 .. T+2+BLOCK_WORDS.
- READ -> DONE on acceptance of the last beat.
- DONE: all outputs 0 except o_busy. Go to IDLE when i_start_read=0. A request held high does not re-trigger a fill.
- READ -> FLUSH if i_start_read=0 before the last beat (abort):
  - No new rd_en; o_r_valid forced 0.
  - Returning in-flight data and buffer contents are discarded.
  - FLUSH -> IDLE when no read is in flight.
- Simultaneous push and pop in the same cycle: occupancy unchanged.
- Buffer overflow is impossible by the issue rule. An assertion must flag push while full.
- o_busy = (state != IDLE).

Decomposition:
- Shared package instr_fill_pkg: state enum t_fill_state (IDLE, READ, DONE, FLUSH), beat and issue counter width constants.
- One sub-module: fill_skid_fifo. Synchronous FIFO of SKID_DEPTH entries with push, pop, flush, empty and full, plus occupancy out.

Test Plan:
- Reset: arst pulse mid-burst at beat 5 -> all outputs 0 in the same cycle. After release, no o_r_valid until a new start.
- Basic fill, ready always high, i_addr=0x0000_1234, memory word = address -> rd_en addresses 0x1200..0x123C in T+1..T+16. Beats with data 0x1200..0x123C in T+3..T+18. o_r_last only at T+18. DONE, then IDLE once start drops.
- Backpressure: i_r_ready low for 3 cycles at beat 4 -> data 0x1210 held stable. Issue stops once occupancy+inflight=2. No lost or duplicated beats; order preserved.
- Alternating i_r_ready (1,0,1,0…) -> exactly 16 beats, last beat flagged. Overflow assertion never fires.
- Abort: i_start_read dropped after beat 6 -> o_r_valid 0 next cycle, no further rd_en. IDLE within 2 cycles. The next fill at 0x40 starts cleanly at beat 0.
- Held request: i_start_read kept high 5 cycles after the last beat -> stays DONE, no rd_en, no second fill.
